// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debounce block.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    localparam int KEY_CNT_W = 16;

    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_DB_TICKS     = 20;
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;

    function automatic logic [KEY_CNT_W-1:0] sat_inc(input logic [KEY_CNT_W-1:0] v);
        return (&v) ? v : v + {{(KEY_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Raw key pins in, debounced levels and event pulses out.
interface key_debounce_if #(parameter int NUM_KEYS = 4);

    logic [NUM_KEYS-1:0] KEY_RAW;
    logic [NUM_KEYS-1:0] KEY_LEVEL;
    logic [NUM_KEYS-1:0] KEY_PRESS;
    logic [NUM_KEYS-1:0] KEY_RELEASE;
    logic [NUM_KEYS-1:0] KEY_REPEAT;
    logic                KEY_ANY;

    modport master (
        output KEY_RAW,
        input  KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_REPEAT, KEY_ANY
    );

    modport slave (
        input  KEY_RAW,
        output KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_REPEAT, KEY_ANY
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, polarity fix and debounce/repeat FSM.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DB_TICKS     = DEF_DB_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam logic                 IDLE_LVL   = ACTIVE_LOW;
    localparam logic [KEY_CNT_W-1:0] DB_LAST    = KEY_CNT_W'(DB_TICKS - 1);
    localparam logic [KEY_CNT_W-1:0] REP_LAST   = KEY_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [KEY_CNT_W-1:0] REP_RELOAD = KEY_CNT_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam bit                   REP_EN     = (REPEAT_DELAY != 0);

    logic                 sync1;
    logic                 sync2;
    logic                 act;
    key_state_t           state;
    logic [KEY_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign act = ACTIVE_LOW ? ~sync2 : sync2;

    // An input change outranks a simultaneous tick, so act is tested before tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (act) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!act) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (cnt == DB_LAST) begin
                            state       <= HELD;
                            key_level   <= 1'b1;
                            press_pulse <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                HELD: begin
                    if (!act) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (REP_EN && cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            cnt          <= REP_RELOAD;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                RELEASE_DB: begin
                    if (act) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == DB_LAST) begin
                            state         <= IDLE;
                            key_level     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounce top: shared tick prescaler feeding one FSM channel per key.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int DB_TICKS     = DEF_DB_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    key_debounce_if.slave bus
);

    localparam int             DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    wire  [NUM_KEYS-1:0] level_vec;
    wire  [NUM_KEYS-1:0] press_vec;
    wire  [NUM_KEYS-1:0] release_vec;
    wire  [NUM_KEYS-1:0] repeat_vec;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DB_TICKS     (DB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk           (PCLK),
            .rst_n         (PRESETn),
            .tick          (tick),
            .raw           (bus.KEY_RAW[i]),
            .key_level     (level_vec[i]),
            .press_pulse   (press_vec[i]),
            .release_pulse (release_vec[i]),
            .repeat_pulse  (repeat_vec[i])
        );
    end

    assign bus.KEY_LEVEL   = level_vec;
    assign bus.KEY_PRESS   = press_vec;
    assign bus.KEY_RELEASE = release_vec;
    assign bus.KEY_REPEAT  = repeat_vec;
    assign bus.KEY_ANY     = |level_vec;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a short tick (4 clocks) and short debounce/repeat windows.
module tb_key_debounce;

    logic PCLK;
    logic PRESETn;

    key_debounce_if #(.NUM_KEYS(4)) bus ();

    key_debounce #(
        .NUM_KEYS     (4),
        .ACTIVE_LOW   (1'b1),
        .TICK_DIV     (4),
        .DB_TICKS     (3),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int testCount = 0;
    int failCount = 0;
    int cyc = 0;
    int overlapCnt = 0;
    int pressCnt[4];
    int releaseCnt[4];
    int repeatCnt[4];
    int pressCyc[4];
    int repCyc2[$];
    int n;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 4; i++) begin
            pressCnt[i]   = 0;
            releaseCnt[i] = 0;
            repeatCnt[i]  = 0;
            pressCyc[i]   = 0;
        end
        repCyc2.delete();
    endtask

    // Advance one clock and tally pulses, sampling 1 time unit after the edge.
    task automatic stepCycle();
        @(posedge PCLK);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (bus.KEY_PRESS[i]) begin
                pressCnt[i]++;
                pressCyc[i] = cyc;
            end
            if (bus.KEY_RELEASE[i]) releaseCnt[i]++;
            if (bus.KEY_REPEAT[i]) begin
                repeatCnt[i]++;
                if (i == 2) repCyc2.push_back(cyc);
            end
        end
        if ((bus.KEY_PRESS & bus.KEY_REPEAT) != 4'h0) overlapCnt++;
    endtask

    task automatic applyStimulus();
        logic [3:0] pressMask;
        int d1;
        int d2;

        PRESETn     = 1'b0;
        bus.KEY_RAW = 4'h0;
        clearCounts();
        repeat (3) stepCycle();
        checkOutput("reset_level", 32'(bus.KEY_LEVEL), 32'h0);
        checkOutput("reset_pulses", 32'(bus.KEY_PRESS | bus.KEY_RELEASE | bus.KEY_REPEAT), 32'h0);
        checkOutput("reset_any", 32'(bus.KEY_ANY), 32'h0);

        bus.KEY_RAW = 4'hF;
        stepCycle();
        PRESETn = 1'b1;
        clearCounts();
        repeat (30) stepCycle();
        checkOutput("idle_level", 32'(bus.KEY_LEVEL), 32'h0);
        checkOutput("idle_press_cnt", 32'(pressCnt[0] + pressCnt[1] + pressCnt[2] + pressCnt[3]), 32'h0);

        // Clean press on key 0.
        clearCounts();
        bus.KEY_RAW[0] = 1'b0;
        n = 0;
        while (!bus.KEY_LEVEL[0] && n < 40) begin
            stepCycle();
            n++;
        end
        checkOutput("press_latency_ok", 32'((n >= 11) && (n <= 15)), 32'h1);
        checkOutput("press_any", 32'(bus.KEY_ANY), 32'h1);
        repeat (3) stepCycle();
        checkOutput("press_cnt0", 32'(pressCnt[0]), 32'h1);
        pressMask = '0;
        for (int i = 0; i < 4; i++) pressMask[i] = (pressCnt[i] != 0);
        checkOutput("press_mask", 32'(pressMask), 32'h1);
        checkOutput("press_level", 32'(bus.KEY_LEVEL), 32'h1);

        // Bounce on key 1: 3-cycle stretches never survive three ticks.
        clearCounts();
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) bus.KEY_RAW[1] = ~bus.KEY_RAW[1];
            stepCycle();
        end
        bus.KEY_RAW[1] = 1'b1;
        repeat (10) stepCycle();
        checkOutput("bounce_level1", 32'(bus.KEY_LEVEL[1]), 32'h0);
        checkOutput("bounce_pulses1", 32'(pressCnt[1] + releaseCnt[1] + repeatCnt[1]), 32'h0);

        // Auto-repeat on key 2: first at +20 cycles, then every 8.
        clearCounts();
        bus.KEY_RAW[2] = 1'b0;
        n = 0;
        while (pressCnt[2] == 0 && n < 30) begin
            stepCycle();
            n++;
        end
        checkOutput("rep_press_seen", 32'(pressCnt[2]), 32'h1);
        repeat (58) stepCycle();
        checkOutput("rep_press_once", 32'(pressCnt[2]), 32'h1);
        checkOutput("rep_count", 32'(repeatCnt[2]), 32'd5);
        d1 = (repCyc2.size() > 0) ? repCyc2[0] - pressCyc[2] : -1;
        d2 = (repCyc2.size() > 1) ? repCyc2[1] - repCyc2[0] : -1;
        checkOutput("rep_first_delay", 32'(d1), 32'd20);
        checkOutput("rep_rate", 32'(d2), 32'd8);
        bus.KEY_RAW[2] = 1'b1;
        repeat (30) stepCycle();
        checkOutput("rep_release_cnt", 32'(releaseCnt[2]), 32'h1);
        checkOutput("rep_release_level", 32'(bus.KEY_LEVEL[2]), 32'h0);

        // Key 3: glitch while held, then a real release.
        bus.KEY_RAW[3] = 1'b0;
        n = 0;
        while (!bus.KEY_LEVEL[3] && n < 30) begin
            stepCycle();
            n++;
        end
        checkOutput("k3_held", 32'(bus.KEY_LEVEL[3]), 32'h1);
        clearCounts();
        bus.KEY_RAW[3] = 1'b1;
        stepCycle();
        bus.KEY_RAW[3] = 1'b0;
        repeat (20) stepCycle();
        checkOutput("glitch_release", 32'(releaseCnt[3]), 32'h0);
        checkOutput("glitch_level", 32'(bus.KEY_LEVEL[3]), 32'h1);
        checkOutput("glitch_no_press", 32'(pressCnt[3]), 32'h0);
        bus.KEY_RAW[3] = 1'b1;
        repeat (30) stepCycle();
        checkOutput("k3_release_cnt", 32'(releaseCnt[3]), 32'h1);
        checkOutput("k3_release_level", 32'(bus.KEY_LEVEL[3]), 32'h0);

        // Asynchronous reset while key 0 is held.
        checkOutput("k0_still_held", 32'(bus.KEY_LEVEL), 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("async_reset_level", 32'(bus.KEY_LEVEL), 32'h0);
        checkOutput("async_reset_any", 32'(bus.KEY_ANY), 32'h0);
        bus.KEY_RAW = 4'hF;
        repeat (3) stepCycle();
        PRESETn = 1'b1;
        clearCounts();
        repeat (40) stepCycle();
        checkOutput("post_reset_release", 32'(releaseCnt[0]), 32'h0);
        checkOutput("post_reset_press", 32'(pressCnt[0] + pressCnt[1] + pressCnt[2] + pressCnt[3]), 32'h0);
        checkOutput("post_reset_level", 32'(bus.KEY_LEVEL), 32'h0);

        checkOutput("press_repeat_overlap", 32'(overlapCnt), 32'h0);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream conditioning stage for the APB key peripheral. Takes raw, bouncing push-button pins from the board and drives clean, debounced levels straight into that peripheral's PORTIN[3:0].
- Also produces single-cycle press, release and auto-repeat pulses, so game logic can sample the fire and direction buttons without software debouncing.
- Uses a shared millisecond-style tick prescaler and one debounce state machine per key.

Parameters:
- NUM_KEYS, 4: number of key channels.
- ACTIVE_LOW, 1: 1 means a raw pin at 0 is pressed; the raw input is inverted after synchronisation.
- TICK_DIV, 50000: PCLK cycles per tick (1 ms at 50 MHz). Must be ≥2.
- DB_TICKS, 20: ticks the input must stay stable before a level change is accepted. Must be ≥1.
- REPEAT_DELAY, 500: ticks held before the first repeat pulse. 0 disables repeat.
- REPEAT_RATE, 100: ticks between subsequent repeat pulses. Must be ≥1.

Ports:
- PCLK  input  1  clock.
- PRESETn  input  1  reset; asynchronous assert, active-low.
- KEY_RAW  input  NUM_KEYS  raw asynchronous button pins.
- KEY_LEVEL  output  NUM_KEYS  debounced level, 1 = pressed; connects to PORTIN.
- KEY_PRESS  output  NUM_KEYS  one-cycle pulse on an accepted press.
- KEY_RELEASE  output  NUM_KEYS  one-cycle pulse on an accepted release.
- KEY_REPEAT  output  NUM_KEYS  one-cycle auto-repeat pulse while held.
- KEY_ANY  output  1  OR of KEY_LEVEL.

Behaviour:
- **Reset:** all outputs are 0, all channels are in IDLE, prescaler count is 0, and sync flops are cleared to the unpressed level (1 if ACTIVE_LOW).
- **Synchroniser:** each bit of KEY_RAW passes through a 2-flop synchroniser. The synced value is then polarity-corrected into `act`.
- **Prescaler:**
  - Free-running counter runs 0..TICK_DIV-1.
  - `tick` is high for exactly one cycle when the count is TICK_DIV-1; the counter then wraps to 0.
  - Because the prescaler is shared and free-running, the debounce window is DB_TICKS-1 to DB_TICKS tick periods.
- **Per-channel FSM:** states IDLE, PRESS_DB, HELD, RELEASE_DB. Tick counter `cnt` is 16 bits, saturating.
  - IDLE: if act=1, go to PRESS_DB with cnt=0.
  - PRESS_DB:
    - act=0: return to IDLE (glitch rejected).
    - else on tick with cnt==DB_TICKS-1: go to HELD, set KEY_LEVEL=1, pulse KEY_PRESS, cnt=0.
    - else on tick: cnt++.
  - HELD:
    - act=0: go to RELEASE_DB with cnt=0.
    - else on tick: cnt++. When REPEAT_DELAY≠0 and cnt reaches REPEAT_DELAY-1, pulse KEY_REPEAT and reload cnt to REPEAT_DELAY-REPEAT_RATE. This gives a first repeat at REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
  - RELEASE_DB:
    - act=1: return to HELD with cnt=0. Repeat timing restarts; no press pulse.
    - else on tick with cnt==DB_TICKS-1: go to IDLE, set KEY_LEVEL=0, pulse KEY_RELEASE.
    - else on tick: cnt++.
- **Output timing:** all outputs are registered. Pulses are high for exactly one PCLK cycle, on the cycle after the transition edge.
- **Simultaneous events:** an input change in the same cycle as `tick` takes priority; the counter is not advanced. KEY_PRESS and KEY_REPEAT never assert in the same cycle.
- **Channel independence:** channels are independent; simultaneous presses on several keys produce simultaneous pulses.
- **Reset mid-operation:** a reset in any state returns that channel to IDLE with no pulses emitted, including during HELD.
- **Latency:** minimum KEY_RAW-to-KEY_LEVEL latency is 2 sync cycles + 1 state-entry cycle + (DB_TICKS-1)·TICK_DIV + 1 cycles, and at most TICK_DIV cycles more.

Decomposition:
- Shared package key_pkg:
  - state encoding (IDLE=2'd0, PRESS_DB=2'd1, HELD=2'd2, RELEASE_DB=2'd3)
  - counter width constant KEY_CNT_W=16
  - default timing constants.
- Sub-module key_debounce_ch: one synchroniser + FSM + counter, instantiated NUM_KEYS times.
- The top level holds the prescaler, the generate loop and the KEY_ANY reduction.

Test Plan (TICK_DIV=4, DB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2):
- **Reset:** hold PRESETn=0 with KEY_RAW=4'h0 → all outputs 0. After release with KEY_RAW=4'hF, outputs stay 0.
- **Clean press:** drive KEY_RAW[0]=0 and hold → KEY_LEVEL[0] rises 11–15 cycles later. KEY_PRESS[0] pulses exactly 1 cycle; other bits stay 0.
- **Bounce rejection:** toggle KEY_RAW[1] every 3 cycles for 40 cycles, then return to 1 → KEY_LEVEL[1] stays 0 and no pulses occur.
- **Auto-repeat:** hold KEY_RAW[2]=0 for 60 cycles → KEY_PRESS once, first KEY_REPEAT 5 ticks (20 cycles) after the press, then every 2 ticks (8 cycles).
- **Release glitch and release:**
  - from HELD, drive a 1-cycle high glitch on KEY_RAW[3] → no KEY_RELEASE.
  - then a sustained high → KEY_RELEASE[3] pulses once and KEY_LEVEL[3] returns to 0.
- **Reset mid-hold:** assert PRESETn=0 while key 0 is HELD → KEY_LEVEL=0 immediately (async). No release pulse is generated after deassertion while the key is released.
